mem_responder: RTL and testbench

- Memory-side responder for the two-bit `mem_operation` / `mem_opdone` word protocol used by the compute FSMs (matrix convolution and similar).
- Accepts one read (01) or write (11) request at a time and services it from an internal word-addressed RAM after a fixed, programmable latency.
- Signals completion with a single-cycle `mem_opdone` pulse.
- A secondary host port lets the CPU/testbench preload operands and read back results while the protocol side is idle.

---
 rtl/mem_if_pkg.sv | 38 +++
 rtl/mem_responder_ram.sv | 32 +++
 rtl/mem_responder.sv | 186 ++++++++++++++++++
 tb/tb_mem_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_if_pkg
// Description : Shared definitions for the two-bit mem_operation/mem_opdone
//               word protocol: op codes, responder state encoding and small
//               helpers used by the responder and the initiator FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

    // Protocol op codes driven by the initiator on mem_operation
    localparam logic [1:0] MEM_OP_NONE    = 2'b00;
    localparam logic [1:0] MEM_OP_READ    = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE   = 2'b11;
    localparam logic [1:0] MEM_OP_ILLEGAL = 2'b10;

    // Width of the latency down-counter (LATENCY range 1..15)
    localparam int unsigned CNT_W = 4;

    // Responder state encoding
    typedef enum logic [1:0] {
        RESP_IDLE    = 2'b00,
        RESP_BUSY    = 2'b01,
        RESP_RESPOND = 2'b10
    } resp_state_t;

    // True for the two op codes that start a protocol transaction
    function automatic logic is_mem_request(input logic [1:0] op);
        return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
    endfunction

    // True for the op codes that leave the RAM port free for the host
    function automatic logic is_mem_quiet(input logic [1:0] op);
        return (op == MEM_OP_NONE) || (op == MEM_OP_ILLEGAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_ram
// Description : Single-port word RAM, synchronous write and combinational
//               read, shared by the protocol engine and the host port.
//               Contents are never cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [DEPTH];

    // Commit a write on the clock edge; the caller guarantees addr < DEPTH
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Memory-side responder for the mem_operation/mem_opdone
//               protocol. Serves one read or write at a time after a fixed
//               LATENCY, pulses mem_opdone for one cycle, then spends one
//               RESPOND cycle ignoring the bus so a request that the
//               initiator is just replacing is never serviced twice. A host
//               port shares the single RAM port whenever the protocol side
//               is idle and not requesting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_operation,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        mem_opdone,
    input  logic        host_en,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_ready,
    output logic        err
);

    localparam int unsigned      c_ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]      c_DEPTH_W  = 32'(DEPTH);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(LATENCY - 1);

    resp_state_t      r_state;
    resp_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_data_o;
    logic             r_opdone;
    logic [31:0]      r_host_rdata;
    logic             r_err;

    logic             w_idle;
    logic             w_req;
    logic             w_illegal;
    logic             w_host_grant;
    logic             w_host_acc;
    logic             w_done;
    logic             w_prot_in_range;
    logic             w_host_in_range;

    logic [c_ADDR_W-1:0] w_ram_addr;
    logic [31:0]         w_ram_wdata;
    logic                w_ram_we;
    logic [31:0]         w_ram_rdata;

    // Protocol always wins the RAM port; the host is granted only when the
    // protocol side is idle and not requesting, and never while in reset.
    assign w_idle          = (r_state == RESP_IDLE);
    assign w_req           = w_idle && is_mem_request(mem_operation);
    assign w_illegal       = w_idle && (mem_operation == MEM_OP_ILLEGAL);
    assign w_host_grant    = reset && w_idle && is_mem_quiet(mem_operation);
    assign w_host_acc      = w_host_grant && host_en;
    assign w_done          = (r_state == RESP_BUSY) && (r_cnt == '0);
    assign w_prot_in_range = (r_addr < c_DEPTH_W);
    assign w_host_in_range = (host_addr < c_DEPTH_W);

    // Single RAM port mux; out-of-range accesses never raise the write enable
    always_comb begin
        w_ram_addr  = r_addr[c_ADDR_W-1:0];
        w_ram_wdata = r_wdata;
        w_ram_we    = w_done && r_op_write && w_prot_in_range;
        if (w_host_acc) begin
            w_ram_addr  = host_addr[c_ADDR_W-1:0];
            w_ram_wdata = host_wdata;
            w_ram_we    = host_we && w_host_in_range;
        end
    end

    mem_responder_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RESP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: RESPOND always returns to IDLE without sampling
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RESP_IDLE: begin
                if (w_req) begin
                    w_state_nxt = RESP_BUSY;
                end
            end
            RESP_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP_RESPOND;
                end
            end
            RESP_RESPOND: begin
                w_state_nxt = RESP_IDLE;
            end
            default: begin
                w_state_nxt = RESP_IDLE;
            end
        endcase
    end

    // Request capture and latency countdown; inputs are ignored once BUSY
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_req) begin
            r_cnt      <= c_CNT_LOAD;
            r_op_write <= (mem_operation == MEM_OP_WRITE);
            r_addr     <= addr_i;
            r_wdata    <= data_i;
        end else if ((r_state == RESP_BUSY) && (r_cnt != '0)) begin
            r_cnt      <= r_cnt - 1'b1;
        end
    end

    // Protocol completion: one-cycle opdone pulse and held read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_opdone <= 1'b0;
            r_data_o <= '0;
        end else begin
            r_opdone <= w_done;
            if (w_done && !r_op_write) begin
                r_data_o <= w_prot_in_range ? w_ram_rdata : 32'h0;
            end
        end
    end

    // Host read data, loaded on the grant edge of a host read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_host_rdata <= '0;
        end else if (w_host_acc && !host_we) begin
            r_host_rdata <= w_host_in_range ? w_ram_rdata : 32'h0;
        end
    end

    // Sticky error: illegal op, out-of-range protocol or host access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_illegal || (w_done && !w_prot_in_range) ||
                     (w_host_acc && !w_host_in_range)) begin
            r_err <= 1'b1;
        end
    end

    assign data_o     = r_data_o;
    assign mem_opdone = r_opdone;
    assign host_rdata = r_host_rdata;
    assign host_ready = w_host_grant;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Two instances
//               (LATENCY 1 and 4) share clock and reset; an array-based
//               memory model predicts read data, held outputs and err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
    import mem_if_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int K_HW = 0;
    localparam int K_HR = 1;
    localparam int K_PW = 2;
    localparam int K_PR = 3;

    logic        clk;
    logic        reset;
    logic [1:0]  op      [2];
    logic [31:0] a_in    [2];
    logic [31:0] d_in    [2];
    logic [31:0] d_out   [2];
    logic        opdone  [2];
    logic        h_en    [2];
    logic        h_we    [2];
    logic [31:0] h_addr  [2];
    logic [31:0] h_wdata [2];
    logic [31:0] h_rdata [2];
    logic        h_ready [2];
    logic        err_o   [2];

    int checks   = 0;
    int failures = 0;
    int lat_of [2];

    // Behavioural model: memory image plus the held / sticky outputs
    logic [31:0] mdl       [2][DEPTH];
    bit          mdl_known [2][DEPTH];
    bit          mdl_err   [2];
    logic [31:0] mdl_do    [2];
    logic [31:0] mdl_hr    [2];

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_operation(op[0]), .addr_i(a_in[0]),
        .data_i(d_in[0]), .data_o(d_out[0]), .mem_opdone(opdone[0]),
        .host_en(h_en[0]), .host_we(h_we[0]), .host_addr(h_addr[0]),
        .host_wdata(h_wdata[0]), .host_rdata(h_rdata[0]),
        .host_ready(h_ready[0]), .err(err_o[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .mem_operation(op[1]), .addr_i(a_in[1]),
        .data_i(d_in[1]), .data_o(d_out[1]), .mem_opdone(opdone[1]),
        .host_en(h_en[1]), .host_we(h_we[1]), .host_addr(h_addr[1]),
        .host_wdata(h_wdata[1]), .host_rdata(h_rdata[1]),
        .host_ready(h_ready[1]), .err(err_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            op[s]   = MEM_OP_NONE;
            h_en[s] = 1'b0;
            h_we[s] = 1'b0;
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_data_o", d_out[s], 32'h0);
            check("rst_opdone", {31'h0, opdone[s]}, 32'h0);
            check("rst_host_rdata", h_rdata[s], 32'h0);
            check("rst_host_ready", {31'h0, h_ready[s]}, 32'h0);
            check("rst_err", {31'h0, err_o[s]}, 32'h0);
        end
        tick();
        tick();
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mdl_err[s] = 1'b0;
            mdl_do[s]  = 32'h0;
            mdl_hr[s]  = 32'h0;
        end
    endtask

    task automatic host_access(input int sel, input bit we, input logic [31:0] adr,
                               input logic [31:0] dat);
        op[sel]      = MEM_OP_NONE;
        h_en[sel]    = 1'b1;
        h_we[sel]    = we;
        h_addr[sel]  = adr;
        h_wdata[sel] = dat;
        #1;
        check("host_ready_idle", {31'h0, h_ready[sel]}, 32'h1);
        tick();
        h_en[sel] = 1'b0;
        h_we[sel] = 1'b0;
    endtask

    task automatic prot_txn(input int sel, input logic [1:0] opc, input logic [31:0] adr,
                            input logic [31:0] dat);
        bit seen;
        int n;
        seen = 1'b0;
        n    = 0;
        op[sel]   = opc;
        a_in[sel] = adr;
        d_in[sel] = dat;
        tick();
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (opdone[sel]) begin
                seen = 1'b1;
                n    = i;
                break;
            end
        end
        op[sel] = MEM_OP_NONE;
        check("opdone_seen", {31'h0, seen}, 32'h1);
        if (seen) check("opdone_latency", n, lat_of[sel]);
        tick();
        check("opdone_width", {31'h0, opdone[sel]}, 32'h0);
    endtask

    // One transaction on either port; model predicts the observed value
    task automatic do_op(input int sel, input int kind, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] obs,
                         output logic [31:0] mexp);
        bit in_r;
        in_r = (adr < DEPTH);
        if (kind == K_HW || kind == K_HR) begin
            host_access(sel, kind == K_HW, adr, dat);
            obs = h_rdata[sel];
        end else begin
            prot_txn(sel, (kind == K_PW) ? MEM_OP_WRITE : MEM_OP_READ, adr, dat);
            obs = d_out[sel];
        end
        if (!in_r) mdl_err[sel] = 1'b1;
        case (kind)
            K_HR: mdl_hr[sel] = in_r ? mdl[sel][int'(adr)] : 32'h0;
            K_PR: mdl_do[sel] = in_r ? mdl[sel][int'(adr)] : 32'h0;
            default: begin
                if (in_r) begin
                    mdl[sel][int'(adr)]       = dat;
                    mdl_known[sel][int'(adr)] = 1'b1;
                end
            end
        endcase
        mexp = (kind == K_HW || kind == K_HR) ? mdl_hr[sel] : mdl_do[sel];
        check("err_flag", {31'h0, err_o[sel]}, {31'h0, mdl_err[sel]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] obs;
        logic [31:0] mexp;
        logic [31:0] adr;
        logic [31:0] sexp [4];
        int          kind;
        int          r;
        int          cnt;
        int          last;
        int          extra;

        lat_of[0] = 1;
        lat_of[1] = 4;
        for (int s = 0; s < 2; s++) begin
            op[s] = MEM_OP_NONE; a_in[s] = '0; d_in[s] = '0;
            h_en[s] = 1'b0; h_we[s] = 1'b0; h_addr[s] = '0; h_wdata[s] = '0;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // Directed vectors on the LATENCY=1 instance (host preload, reads, held outputs)
        tbl[0]  = '{K_HW, 32'd10,  32'd5,          32'h0};
        tbl[1]  = '{K_PR, 32'd10,  32'd0,          32'd5};
        tbl[2]  = '{K_PW, 32'd7,   32'hDEADBEEF,   32'd5};
        tbl[3]  = '{K_HR, 32'd7,   32'd0,          32'hDEADBEEF};
        tbl[4]  = '{K_HW, 32'd1,   32'd3,          32'hDEADBEEF};
        tbl[5]  = '{K_HW, 32'd2,   32'd3,          32'hDEADBEEF};
        tbl[6]  = '{K_HW, 32'd3,   32'd2,          32'hDEADBEEF};
        tbl[7]  = '{K_HW, 32'd4,   32'd2,          32'hDEADBEEF};
        tbl[8]  = '{K_HW, 32'd255, 32'hA5A5A5A5,   32'hDEADBEEF};
        tbl[9]  = '{K_PR, 32'd255, 32'd0,          32'hA5A5A5A5};
        tbl[10] = '{K_PW, 32'd0,   32'h0BADF00D,   32'hA5A5A5A5};
        tbl[11] = '{K_HR, 32'd0,   32'd0,          32'h0BADF00D};
        for (int i = 0; i < 12; i++) begin
            do_op(0, tbl[i].kind, tbl[i].addr, tbl[i].data, obs, mexp);
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // Host request alongside a protocol read and during BUSY: never granted
        op[0] = MEM_OP_READ; a_in[0] = 32'd7;
        h_en[0] = 1'b1; h_we[0] = 1'b1; h_addr[0] = 32'd7; h_wdata[0] = 32'hBAD0BAD0;
        #1;
        check("t2_ready_vs_req", {31'h0, h_ready[0]}, 32'h0);
        tick();
        check("t2_ready_busy", {31'h0, h_ready[0]}, 32'h0);
        tick();
        op[0] = MEM_OP_NONE;
        check("t2_opdone", {31'h0, opdone[0]}, 32'h1);
        check("t2_data_o", d_out[0], 32'hDEADBEEF);
        #1;
        check("t2_ready_respond", {31'h0, h_ready[0]}, 32'h0);
        h_en[0] = 1'b0; h_we[0] = 1'b0;
        mdl_do[0] = 32'hDEADBEEF;
        tick();
        do_op(0, K_HR, 32'd7, 32'd0, obs, mexp);
        check("t2_host_rd7", obs, 32'hDEADBEEF);

        // Streamed reads: op held at READ, address advanced on each opdone
        sexp[0] = 32'd3; sexp[1] = 32'd3; sexp[2] = 32'd2; sexp[3] = 32'd2;
        op[0] = MEM_OP_READ; a_in[0] = 32'd1;
        cnt = 0; last = 0; extra = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            if (opdone[0]) begin
                if (cnt < 4) begin
                    check("stream_data", d_out[0], sexp[cnt]);
                    check("stream_interval", cyc - last, (cnt == 0) ? 2 : 3);
                    last = cyc;
                    cnt++;
                    if (cnt < 4) a_in[0] = 32'(cnt + 1);
                    else op[0] = MEM_OP_NONE;
                end else begin
                    extra++;
                end
            end
        end
        check("stream_count", cnt, 4);
        check("stream_extra", extra, 0);
        mdl_do[0] = 32'd2;

        // Out-of-range read and host aliasing attempt: no wrap, err sticky
        do_op(0, K_PR, 32'd300, 32'd0, obs, mexp);
        check("t4_data_o", obs, 32'h0);
        check("t4_err", {31'h0, err_o[0]}, 32'h1);
        do_op(0, K_HW, 32'd5, 32'h00000055, obs, mexp);
        do_op(0, K_HW, 32'd261, 32'h66666666, obs, mexp);
        do_op(0, K_HR, 32'd5, 32'd0, obs, mexp);
        check("t4_no_alias", obs, 32'h00000055);
        do_op(0, K_HR, 32'h80000005, 32'd0, obs, mexp);
        check("t4_far_read", obs, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_err_sticky", {31'h0, err_o[0]}, 32'h1);
        end
        apply_reset();

        // Illegal op for three cycles: host still granted, no opdone, err set
        check("t5_err_pre", {31'h0, err_o[0]}, 32'h0);
        op[0] = MEM_OP_ILLEGAL;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_host_ready", {31'h0, h_ready[0]}, 32'h1);
            tick();
            check("t5_no_opdone", {31'h0, opdone[0]}, 32'h0);
        end
        op[0] = MEM_OP_NONE;
        mdl_err[0] = 1'b1;
        check("t5_err", {31'h0, err_o[0]}, 32'h1);

        // Reset in the middle of a LATENCY=4 write abandons it
        do_op(1, K_HW, 32'd20, 32'h11112222, obs, mexp);
        op[1] = MEM_OP_WRITE; a_in[1] = 32'd20; d_in[1] = 32'h99999999;
        tick();
        tick();
        #2;
        reset = 1'b0;
        op[0] = MEM_OP_NONE;
        op[1] = MEM_OP_NONE;
        #1;
        check("t6_err_cleared", {31'h0, err_o[0]}, 32'h0);
        extra = 0;
        tick();
        tick();
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mdl_err[s] = 1'b0; mdl_do[s] = 32'h0; mdl_hr[s] = 32'h0;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (opdone[1]) extra++;
        end
        check("t6_no_opdone", extra, 0);
        do_op(1, K_HR, 32'd20, 32'd0, obs, mexp);
        check("t6_prior_value", obs, 32'h11112222);

        // Randomised traffic on both latencies against the model
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 60; i++) begin
                kind = int'($urandom_range(0, 3));
                r    = int'($urandom_range(0, 9));
                if (r == 0)      adr = DEPTH + $urandom_range(0, 5000);
                else if (r == 1) adr = 32'hFFFFFF00 | $urandom_range(0, 255);
                else             adr = $urandom_range(0, 31);
                if ((kind == K_HR || kind == K_PR) && adr < DEPTH && !mdl_known[s][int'(adr)])
                    kind = kind - 1;
                do_op(s, kind, adr, $urandom(), obs, mexp);
                check("rand_value", obs, mexp);
                r = int'($urandom_range(0, 2));
                for (int k = 0; k < r; k++) tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
